// File: rtl/multicycle_control_if.sv
// Instruction handshake, memory status and datapath control bundle of the multicycle control unit.
interface multicycle_control_if #(
   parameter int ALUOP_W = 4
);
   logic [31:0]        instruction;
   logic               instr_valid;
   logic               instr_ready;
   logic               mem_ready;
   logic               RegWrite;
   logic               ALUSrc;
   logic [ALUOP_W-1:0] ALUop;
   logic               MemWrite;
   logic               MemRead;
   logic               MemtoReg;
   logic               illegal;
   logic               mem_err;
   logic [31:0]        instr_retired;

   modport master (
      output instruction, instr_valid, mem_ready,
      input  instr_ready, RegWrite, ALUSrc, ALUop, MemWrite, MemRead, MemtoReg,
             illegal, mem_err, instr_retired
   );

   modport slave (
      input  instruction, instr_valid, mem_ready,
      output instr_ready, RegWrite, ALUSrc, ALUop, MemWrite, MemRead, MemtoReg,
             illegal, mem_err, instr_retired
   );
endinterface

// File: rtl/multicycle_control.sv
// RV32I multicycle control FSM: IDLE -> DECODE -> EXEC -> [MEM] -> [WB].
// Define PERF_COUNTER_EN to enable the retired-instruction counter.
module multicycle_control #(
   parameter int MEM_WAIT_MAX = 15,
   parameter int ALUOP_W      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.slave  io_ctl
);
   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
   typedef enum logic [1:0] {C_ALU, C_LOAD, C_STORE, C_ILL} cls_t;

   localparam logic [ALUOP_W-1:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                                  OP_XOR = 4'b0011, OP_SLL = 4'b0100, OP_SRL = 4'b0101,
                                  OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SRA = 4'b1000;
   localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

   logic [6:0]         w_op;
   logic [2:0]         w_f3;
   logic [6:0]         w_f7;
   cls_t               w_cls;
   logic [ALUOP_W-1:0] w_aluop;
   logic               w_alusrc;
   logic               w_unused;

   state_t             r_state;
   cls_t               r_cls;
   logic [4:0]         r_rd;
   logic [ALUOP_W-1:0] r_aluop_dec;
   logic               r_alusrc_dec;
   logic [7:0]         r_wait;
   logic               r_ready, r_regwrite, r_alusrc, r_memwrite, r_memread, r_memtoreg;
   logic               r_illegal, r_mem_err;
   logic [ALUOP_W-1:0] r_aluop;

   assign w_op     = io_ctl.instruction[6:0];
   assign w_f3     = io_ctl.instruction[14:12];
   assign w_f7     = io_ctl.instruction[31:25];
   assign w_unused = ^io_ctl.instruction[24:15];

   // Decode straight off the bus so the illegal pulse lands in the DECODE cycle.
   always_comb begin
      w_cls    = C_ILL;
      w_aluop  = OP_AND;
      w_alusrc = 1'b0;
      case (w_op)
         7'b0110011: begin
            w_cls = C_ALU;
            case (w_f3)
               3'b000: if (w_f7 == 7'b0000000) w_aluop = OP_ADD;
                       else if (w_f7 == 7'b0100000) w_aluop = OP_SUB;
                       else w_cls = C_ILL;
               3'b001: if (w_f7 == 7'b0000000) w_aluop = OP_SLL; else w_cls = C_ILL;
               3'b010: if (w_f7 == 7'b0000000) w_aluop = OP_SLT; else w_cls = C_ILL;
               3'b100: if (w_f7 == 7'b0000000) w_aluop = OP_XOR; else w_cls = C_ILL;
               3'b101: if (w_f7 == 7'b0000000) w_aluop = OP_SRL;
                       else if (w_f7 == 7'b0100000) w_aluop = OP_SRA;
                       else w_cls = C_ILL;
               3'b110: if (w_f7 == 7'b0000000) w_aluop = OP_OR;  else w_cls = C_ILL;
               3'b111: if (w_f7 == 7'b0000000) w_aluop = OP_AND; else w_cls = C_ILL;
               default: w_cls = C_ILL;
            endcase
         end
         7'b0010011: begin
            w_cls    = C_ALU;
            w_alusrc = 1'b1;
            case (w_f3)
               3'b000:  w_aluop = OP_ADD;
               3'b010:  w_aluop = OP_SLT;
               3'b100:  w_aluop = OP_XOR;
               3'b110:  w_aluop = OP_OR;
               3'b111:  w_aluop = OP_AND;
               default: w_cls   = C_ILL;
            endcase
         end
         7'b0000011: if (w_f3 == 3'b010) begin
            w_cls = C_LOAD; w_aluop = OP_ADD; w_alusrc = 1'b1;
         end
         7'b0100011: if (w_f3 == 3'b010) begin
            w_cls = C_STORE; w_aluop = OP_ADD; w_alusrc = 1'b1;
         end
         default: w_cls = C_ILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cls        <= C_ILL;
         r_rd         <= '0;
         r_aluop_dec  <= '0;
         r_alusrc_dec <= 1'b0;
         r_wait       <= '0;
         r_ready      <= 1'b1;
         r_regwrite   <= 1'b0;
         r_alusrc     <= 1'b0;
         r_aluop      <= '0;
         r_memwrite   <= 1'b0;
         r_memread    <= 1'b0;
         r_memtoreg   <= 1'b0;
         r_illegal    <= 1'b0;
         r_mem_err    <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         r_mem_err <= 1'b0;
         case (r_state)
            S_IDLE: if (io_ctl.instr_valid && r_ready) begin
               r_state      <= S_DECODE;
               r_ready      <= 1'b0;
               r_cls        <= w_cls;
               r_rd         <= io_ctl.instruction[11:7];
               r_aluop_dec  <= w_aluop;
               r_alusrc_dec <= w_alusrc;
               r_illegal    <= (w_cls == C_ILL);
            end
            S_DECODE: if (r_cls == C_ILL) begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end else begin
               r_state  <= S_EXEC;
               r_aluop  <= r_aluop_dec;
               r_alusrc <= r_alusrc_dec;
            end
            S_EXEC: begin
               r_wait <= '0;
               if (r_cls == C_LOAD) begin
                  r_state   <= S_MEM;
                  r_memread <= 1'b1;
               end else if (r_cls == C_STORE) begin
                  r_state    <= S_MEM;
                  r_memwrite <= 1'b1;
               end else begin
                  r_state    <= S_WB;
                  r_regwrite <= (r_rd != 5'd0);
                  r_memtoreg <= 1'b0;
               end
            end
            S_MEM: begin
               // mem_ready on the last allowed cycle still completes the access.
               if (io_ctl.mem_ready) begin
                  r_memread  <= 1'b0;
                  r_memwrite <= 1'b0;
                  if (r_cls == C_LOAD) begin
                     r_state    <= S_WB;
                     r_regwrite <= (r_rd != 5'd0);
                     r_memtoreg <= 1'b1;
                  end else begin
                     r_state  <= S_IDLE;
                     r_ready  <= 1'b1;
                     r_aluop  <= '0;
                     r_alusrc <= 1'b0;
                  end
               end else if (r_wait == WAIT_LAST) begin
                  r_state    <= S_IDLE;
                  r_ready    <= 1'b1;
                  r_memread  <= 1'b0;
                  r_memwrite <= 1'b0;
                  r_mem_err  <= 1'b1;
                  r_aluop    <= '0;
                  r_alusrc   <= 1'b0;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            S_WB: begin
               r_state    <= S_IDLE;
               r_ready    <= 1'b1;
               r_regwrite <= 1'b0;
               r_memtoreg <= 1'b0;
               r_aluop    <= '0;
               r_alusrc   <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign io_ctl.instr_ready = r_ready;
   assign io_ctl.RegWrite    = r_regwrite;
   assign io_ctl.ALUSrc      = r_alusrc;
   assign io_ctl.ALUop       = r_aluop;
   assign io_ctl.MemWrite    = r_memwrite;
   assign io_ctl.MemRead     = r_memread;
   assign io_ctl.MemtoReg    = r_memtoreg;
   assign io_ctl.illegal     = r_illegal;
   assign io_ctl.mem_err     = r_mem_err;

`ifdef PERF_COUNTER_EN
   logic [31:0] r_retired;
   logic        w_retire;

   // Completion is WB exit, or a store leaving MEM with its acknowledge.
   assign w_retire = (r_state == S_WB) ||
                     (r_state == S_MEM && r_cls == C_STORE && io_ctl.mem_ready);

   always_ff @(posedge clk) begin
      if (reset)         r_retired <= '0;
      else if (w_retire) r_retired <= r_retired + 32'd1;
   end

   assign io_ctl.instr_retired = r_retired;
`else
   assign io_ctl.instr_retired = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver queues expected per-instruction traces, monitor checks them.
module tb_multicycle_control;
`ifdef PERF_COUNTER_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      int aluop; int alusrc; int dec_clean;
      int rd_n; int wr_n; int rw_n; int rw_at; int m2r_n;
      int ill_at; int err_at; int lat; int dret;
   } rec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   idle_bad = 0;
   rec_t sb[$];

   multicycle_control_if #(.ALUOP_W(4)) bus ();
   multicycle_control #(.MEM_WAIT_MAX(15), .ALUOP_W(4)) dut (.clk(clk), .reset(reset), .io_ctl(bus));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   function automatic rec_t mk(int aluop, int alusrc, int rd_n, int wr_n, int rw_at, int m2r_n,
                               int ill_at, int err_at, int lat, int dret);
      rec_t r;
      r.aluop = aluop; r.alusrc = alusrc; r.dec_clean = 1;
      r.rd_n = rd_n; r.wr_n = wr_n; r.rw_at = rw_at; r.rw_n = (rw_at >= 0) ? 1 : 0;
      r.m2r_n = m2r_n; r.ill_at = ill_at; r.err_at = err_at; r.lat = lat;
      r.dret = PERF ? dret : 0;
      return r;
   endfunction

   // Monitor: builds a trace from accept until instr_ready returns, then compares.
   bit          in_tr = 1'b0;
   int          off;
   rec_t        got;
   logic [31:0] ret0;

   always @(negedge clk) begin
      if (in_tr) begin
         off++;
         if (bus.MemRead)  got.rd_n++;
         if (bus.MemWrite) got.wr_n++;
         if (bus.RegWrite) begin got.rw_n++; if (got.rw_at < 0) got.rw_at = off; end
         if (bus.MemtoReg) got.m2r_n++;
         if (bus.illegal && got.ill_at < 0) got.ill_at = off;
         if (bus.mem_err && got.err_at < 0) got.err_at = off;
         if (off == 1) got.dec_clean = (bus.ALUop == 4'd0 && bus.ALUSrc == 1'b0) ? 1 : 0;
         if (off == 2) begin got.aluop = int'(bus.ALUop); got.alusrc = int'(bus.ALUSrc); end
         if (bus.instr_ready || off > 60) begin
            rec_t e;
            in_tr = 1'b0;
            got.lat  = bus.instr_ready ? off : -1;
            got.dret = int'(bus.instr_retired - ret0);
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("aluop",     got.aluop,     e.aluop);
               chk("alusrc",    got.alusrc,    e.alusrc);
               chk("dec_clean", got.dec_clean, e.dec_clean);
               chk("memread_n", got.rd_n,      e.rd_n);
               chk("memwrite_n",got.wr_n,      e.wr_n);
               chk("regwrite_n",got.rw_n,      e.rw_n);
               chk("regwrite_at",got.rw_at,    e.rw_at);
               chk("memtoreg_n",got.m2r_n,     e.m2r_n);
               chk("illegal_at",got.ill_at,    e.ill_at);
               chk("mem_err_at",got.err_at,    e.err_at);
               chk("latency",   got.lat,       e.lat);
               chk("retired_d", got.dret,      e.dret);
            end
         end
      end else if (!reset) begin
         if (bus.RegWrite || bus.MemRead || bus.MemWrite || bus.MemtoReg || bus.illegal || bus.mem_err)
            idle_bad++;
      end
      if (!in_tr && bus.instr_valid && bus.instr_ready && !reset) begin
         in_tr = 1'b1;
         off   = 0;
         ret0  = bus.instr_retired;
         got   = '{default: 0};
         got.rw_at = -1; got.ill_at = -1; got.err_at = -1; got.aluop = -1; got.alusrc = -1;
      end
   end

   // Driver: one instruction; mem_ready pulse at offset mr_at, reset pulse at offset rst_at.
   task automatic run(input logic [31:0] ins, input int mr_at, input int rst_at, input bit mr_hold,
                      input rec_t e);
      sb.push_back(e);
      bus.instruction = ins;
      bus.instr_valid = 1'b1;
      bus.mem_ready   = mr_hold;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      bus.instruction = '0;
      for (int o = 1; o < 40; o++) begin
         if (bus.instr_ready) break;
         bus.mem_ready = mr_hold || (o == mr_at);
         reset         = (o == rst_at);
         @(posedge clk); #1;
      end
      bus.mem_ready = 1'b0;
      reset         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      reset           = 1'b1;
      bus.instruction = 32'h003080B3;
      bus.instr_valid = 1'b1;
      bus.mem_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready",    int'(bus.instr_ready), 1);
      chk("rst_regwrite", int'(bus.RegWrite), 0);
      chk("rst_alusrc",   int'(bus.ALUSrc), 0);
      chk("rst_aluop",    int'(bus.ALUop), 0);
      chk("rst_memwrite", int'(bus.MemWrite), 0);
      chk("rst_memread",  int'(bus.MemRead), 0);
      chk("rst_memtoreg", int'(bus.MemtoReg), 0);
      chk("rst_illegal",  int'(bus.illegal), 0);
      chk("rst_mem_err",  int'(bus.mem_err), 0);
      chk("rst_retired",  int'(bus.instr_retired), 0);
      reset           = 1'b0;
      bus.instr_valid = 1'b0;
      bus.mem_ready   = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ready", int'(bus.instr_ready), 1);

      //        instr         mr  rst hold   aluop src rd wr rw_at m2r ill err lat dret
      run(32'h00812283,  -1,  3, 1'b0, mk(2, 1, 1,  0, -1, 0, -1, -1,  4, 0)); // lw, reset in MEM
      run(32'h003080B3,  -1, -1, 1'b1, mk(2, 0, 0,  0,  3, 0, -1, -1,  4, 1)); // add, mem_ready ignored
      run(32'h00812283,   5, -1, 1'b0, mk(2, 1, 3,  0,  6, 1, -1, -1,  7, 1)); // lw, ready on 3rd MEM
      run(32'h00512223,  -1, -1, 1'b0, mk(2, 1, 0, 15, -1, 0, -1, 18, 18, 0)); // sw timeout
      run(32'h0000007F,  -1, -1, 1'b0, mk(0, 0, 0,  0, -1, 0,  1, -1,  2, 0)); // illegal opcode
      run(32'h40628233,  -1, -1, 1'b0, mk(6, 0, 0,  0,  3, 0, -1, -1,  4, 1)); // sub
      run(32'h00100013,  -1, -1, 1'b0, mk(2, 1, 0,  0, -1, 0, -1, -1,  4, 1)); // addi x0
      run(32'h00512223,   3, -1, 1'b0, mk(2, 1, 0,  1, -1, 0, -1, -1,  4, 1)); // sw, immediate ready
      run(32'h00512223,  17, -1, 1'b0, mk(2, 1, 0, 15, -1, 0, -1, -1, 18, 1)); // sw, ready at limit
      run(32'h4053D1B3,  -1, -1, 1'b0, mk(8, 0, 0,  0,  3, 0, -1, -1,  4, 1)); // sra
      run(32'h02208033,  -1, -1, 1'b0, mk(0, 0, 0,  0, -1, 0,  1, -1,  2, 0)); // mul -> illegal
      run(32'hFFF0C113,  -1, -1, 1'b0, mk(3, 1, 0,  0,  3, 0, -1, -1,  4, 1)); // xori

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk("sb_drain", sb.size(), 0);
      chk("idle_strobes", idle_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control unit for the RV32I datapath. Accepts a 32-bit instruction by valid/ready handshake, decodes it, and sequences it through DECODE/EXEC/MEM/WB.
- Drives the datapath control inputs RegWrite, ALUSrc, ALUop, MemWrite, MemRead, MemtoReg, in the encoding the datapath consumes.
- Sits between instruction fetch and the datapath. It is the producer of the datapath's control bundle.

Parameters:
- MEM_WAIT_MAX, 15: max cycles spent in MEM waiting for mem_ready before abort (1..255).
- ALUOP_W, 4: ALUop width. Fixed at 4 for the current datapath.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instruction  in  32  instruction word, sampled on accept
- instr_valid  in  1  instruction presented
- instr_ready  out  1  unit can accept (IDLE only)
- mem_ready  in  1  data memory completed current read/write
- RegWrite  out  1  register file write strobe
- ALUSrc  out  1  0=rs2, 1=immediate
- ALUop  out  4  ALU operation
- MemWrite  out  1  data memory write
- MemRead  out  1  data memory read
- MemtoReg  out  1  writeback source: 1=memory, 0=ALU
- illegal  out  1  one-cycle pulse, unsupported instruction
- mem_err  out  1  one-cycle pulse, memory timeout
- instr_retired  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- All outputs are registered and reflect the current state. The state is held in a one-hot or binary FSM: IDLE, DECODE, EXEC, MEM, WB.
- Reset values: state IDLE, instr_ready=1, all other outputs 0, latched instruction cleared. Handshakes are ignored while reset=1.
- Accept: instr_valid && instr_ready in IDLE latches the instruction; the next state is DECODE. There is no accept in any other state.
- DECODE classifies the instruction by opcode[6:0]:
  - 0110011: R-type.
  - 0010011: I-ALU.
  - 0000011 with funct3=010: LW.
  - 0100011 with funct3=010: SW.
  - Anything else, or an unsupported funct3/funct7: illegal=1 for one cycle, then IDLE. No strobes are asserted.
- ALUop encoding, from funct3/funct7[5]:
  - AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000.
  - I-ALU supports addi/andi/ori/xori/slti.
  - LW/SW use ADD (0010).
- ALUSrc: 0 for R-type; 1 for I-ALU, LW, SW.
- ALUop and ALUSrc are valid from EXEC to the end of the instruction, and are 0 in IDLE/DECODE.
- Sequences, where T is the accept cycle:
  - R/I-ALU: DECODE T+1, EXEC T+2, WB T+3 (RegWrite=1, MemtoReg=0), IDLE T+4.
  - LW: DECODE, EXEC, then MEM with MemRead=1 held until mem_ready, then WB (RegWrite=1, MemtoReg=1), then IDLE.
  - SW: DECODE, EXEC, then MEM with MemWrite=1 held until mem_ready, then IDLE. No WB.
- mem_ready is sampled only in MEM. The cycle where mem_ready=1 is the last MEM cycle. mem_ready in any other state is ignored.
- Timeout: a wait counter is cleared on MEM entry and increments each MEM cycle without mem_ready.
  - When it reaches MEM_WAIT_MAX, MemRead/MemWrite drop, mem_err pulses one cycle, and the FSM returns to IDLE with no RegWrite.
  - If mem_ready=1 in the same cycle as the limit, the access completes normally.
- rd=x0: WB is still entered, but RegWrite stays 0.
- RegWrite, MemWrite, MemRead and MemtoReg are never asserted outside WB/MEM as specified above.
- Reset mid-operation: the next cycle is IDLE with all strobes 0. The in-flight instruction is discarded and not counted.

Optional Feature:
- PERF_COUNTER_EN defined: instr_retired increments by 1 on each instruction completion:
  - WB exit;
  - SW MEM exit with mem_ready.
  - It does not increment for illegal or mem_err. It wraps from 0xFFFFFFFF to 0 and resets to 0.
- PERF_COUNTER_EN undefined: instr_retired is tied to 0 and no counter logic exists.

Test Plan:
- add x1,x1,x3 (0x003080B3) accepted at T -> ALUop=0010, ALUSrc=0 at T+2; RegWrite=1, MemtoReg=0 only at T+3; instr_ready=1 at T+4.
- lw x5,8(x2) (0x00812283), mem_ready raised on the 3rd MEM cycle -> MemRead=1 for exactly 3 cycles; next cycle RegWrite=1, MemtoReg=1; ALUop=0010, ALUSrc=1.
- sw x5,4(x2) (0x00512223) with mem_ready held 0 and MEM_WAIT_MAX=15 -> MemWrite=1 for 15 cycles, then mem_err pulse, no RegWrite; with PERF_COUNTER_EN, instr_retired unchanged.
- 0x0000007F, then sub x4,x5,x6 (0x40628233) -> illegal pulse at T+1 and no strobes; then ALUop=0110 for sub.
- addi x0,x0,1 (0x00100013) -> WB entered, RegWrite stays 0; with PERF_COUNTER_EN, instr_retired +1.
- reset=1 during the MEM cycle of an LW -> the next cycle shows IDLE, instr_ready=1, MemRead=0, and no RegWrite follows.
